// File: rtl/ysyx_24110006_fetch_pkg.sv
// Shared fetch/decode constants: opcodes, reset PC, NOP encoding, state and packet types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_24110006_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_DROP
   } fetch_state_t;

   // Everything decode receives for one instruction.
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        fault;
   } fetch_pkt_t;

endpackage

// File: rtl/ysyx_24110006_fetch_if.sv
// Bus bundles for the fetch stage: memory read port and decode-side output port.
// Latency: n/a (wires only).
// Backpressure: mem uses req_valid/req_ready, decode uses valid/ready.
//  mem: req_valid, addr (master out); req_ready, rsp_valid, rdata, rsp_err (master in)
//  dec: pkt, valid (master out); ready (master in)
interface ysyx_24110006_fetch_mem_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        rsp_err;

   modport master (output req_valid, addr, input req_ready, rsp_valid, rdata, rsp_err);
   modport slave  (input req_valid, addr, output req_ready, rsp_valid, rdata, rsp_err);
endinterface

interface ysyx_24110006_fetch_dec_if;
   import ysyx_24110006_fetch_pkg::*;
   fetch_pkt_t pkt;
   logic       valid;
   logic       ready;

   modport master (output pkt, valid, input ready);
   modport slave  (input pkt, valid, output ready);
endinterface

// File: rtl/ysyx_24110006_fetch_immgen.sv
// Immediate predecoder: RISC-V instruction word -> sign/zero-extended immediate.
// Latency: combinational.
// Backpressure: none.
//  i_inst  in  32  instruction word
//  o_imm   out 32  immediate selected by opcode; 0 for opcodes without one
module ysyx_24110006_immgen
   import ysyx_24110006_fetch_pkg::*;
(
   input  logic [31:0] i_inst,
   output logic [31:0] o_imm
);

   always_comb begin
      o_imm = '0;
      case (i_inst[6:0])
         OP_IMM, OP_JALR, OP_LOAD, OP_SYSTEM:
            o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
         OP_LUI, OP_AUIPC:
            o_imm = {i_inst[31:12], 12'b0};
         OP_JAL:
            o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
         OP_STORE:
            o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         OP_BRANCH:
            o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
         // funct7 is handed to decode in the immediate slot for R-type
         OP_REG:
            o_imm = {25'b0, i_inst[31:25]};
         default:
            o_imm = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_24110006_fetch.sv
// Fetch stage: owns the PC, reads one word per instruction, presents {inst, imm, pc, fault} to decode.
// Latency: response in cycle M -> dec.valid in M+1; at least 3 cycles per instruction.
// Backpressure: holds the output and issues no new request until decode asserts ready.
//  i_clock, i_reset (sync, active high), mem (read port), dec (to decode),
//  i_redirect / i_redirect_pc (new PC from execute/writeback, highest priority after reset)
module ysyx_24110006_fetch
   import ysyx_24110006_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                             i_clock,
   input  logic                             i_reset,
   ysyx_24110006_fetch_mem_if.master        mem,
   ysyx_24110006_fetch_dec_if.master        dec,
   input  logic                             i_redirect,
   input  logic [31:0]                      i_redirect_pc
);

   fetch_state_t state_q;
   logic [31:0]  pc_q;
   fetch_pkt_t   pkt_q;
   logic         valid_q;
   logic [31:0]  imm;
   logic         misaligned;
   logic         req_vld;
   logic         req_hs;

   ysyx_24110006_immgen u_immgen (
      .i_inst (mem.rdata),
      .o_imm  (imm)
   );

   assign misaligned = |pc_q[1:0];
   // A misaligned PC never reaches the bus; the fault is raised locally instead.
   assign req_vld    = (state_q == ST_REQ) && !misaligned && !i_reset;
   assign req_hs     = req_vld && mem.req_ready;

   assign mem.req_valid = req_vld;
   assign mem.addr      = pc_q;
   assign dec.pkt       = pkt_q;
   assign dec.valid     = valid_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         pkt_q   <= '{inst: 32'h0, imm: 32'h0, pc: RESET_PC, fault: 1'b0};
      end else if (i_redirect) begin
         pc_q    <= i_redirect_pc;
         valid_q <= 1'b0;
         case (state_q)
            // A request accepted this cycle still owes us a response: swallow it.
            ST_REQ:  state_q <= req_hs ? ST_DROP : ST_REQ;
            ST_WAIT: state_q <= mem.rsp_valid ? ST_REQ : ST_DROP;
            ST_HOLD: state_q <= ST_REQ;
            // The single outstanding response may land in this same cycle; once it
            // has, nothing else is coming, so waiting on would stall forever.
            ST_DROP: state_q <= mem.rsp_valid ? ST_REQ : ST_DROP;
            default: state_q <= ST_REQ;
         endcase
      end else begin
         case (state_q)
            ST_REQ: begin
               if (misaligned) begin
                  pkt_q   <= '{inst: NOP_INST, imm: 32'h0, pc: pc_q, fault: 1'b1};
                  valid_q <= 1'b1;
                  pc_q    <= pc_q + 32'd4;
                  state_q <= ST_HOLD;
               end else if (mem.req_ready) begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem.rsp_valid) begin
                  if (mem.rsp_err) begin
                     pkt_q <= '{inst: NOP_INST, imm: 32'h0, pc: pc_q, fault: 1'b1};
                  end else begin
                     pkt_q <= '{inst: mem.rdata, imm: imm, pc: pc_q, fault: 1'b0};
                  end
                  valid_q <= 1'b1;
                  pc_q    <= pc_q + 32'd4;
                  state_q <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (dec.ready) begin
                  valid_q <= 1'b0;
                  state_q <= ST_REQ;
               end
            end
            ST_DROP: begin
               if (mem.rsp_valid) begin
                  state_q <= ST_REQ;
               end
            end
            default: state_q <= ST_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24110006_fetch.sv
module tb_ysyx_24110006_fetch;
   import ysyx_24110006_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   ysyx_24110006_fetch_mem_if mem_bus ();
   ysyx_24110006_fetch_dec_if dec_bus ();

   ysyx_24110006_fetch #(.RESET_PC(32'h3000_0000)) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .mem           (mem_bus),
      .dec           (dec_bus),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc)
   );

   int checks = 0;
   int passes = 0;

   // Reference immediate: built from shifts and masks of the word.
   function automatic logic [31:0] ref_imm(input logic [31:0] w);
      logic [31:0] sgn;
      sgn = {32{w[31]}};
      case (w & 32'h7f)
         32'h13, 32'h67, 32'h03, 32'h73: ref_imm = (sgn << 12) | (w >> 20);
         32'h37, 32'h17:                 ref_imm = w & 32'hffff_f000;
         32'h6f: ref_imm = (sgn << 20) | (w & 32'h000f_f000) | (((w >> 20) & 32'h1) << 11)
                         | (((w >> 21) & 32'h3ff) << 1);
         32'h23: ref_imm = (sgn << 12) | ((w >> 25) << 5) | ((w >> 7) & 32'h1f);
         32'h63: ref_imm = (sgn << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3f) << 5)
                         | (((w >> 8) & 32'hf) << 1);
         32'h33: ref_imm = w >> 25;
         default: ref_imm = 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [11];
      logic [31:0] r;
      ops = '{7'h13, 7'h67, 7'h03, 7'h73, 7'h37, 7'h17, 7'h6f, 7'h23, 7'h63, 7'h33, 7'h7f};
      r = $urandom;
      rand_inst = {r[31:7], ops[$urandom_range(0, 10)]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_bus.req_ready = 1'b0;
      mem_bus.rsp_valid = 1'b0;
      mem_bus.rdata     = 32'h0;
      mem_bus.rsp_err   = 1'b0;
      dec_bus.ready     = 1'b0;
      redirect          = 1'b0;
      redirect_pc       = 32'h0;
   endtask

   // From REQ at an aligned pc: one request, one-cycle response; ends in HOLD.
   task automatic fetch_one(input logic [31:0] w, input logic err);
      mem_bus.req_ready = 1'b1;
      step();
      mem_bus.req_ready = 1'b0;
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rdata     = w;
      mem_bus.rsp_err   = err;
      step();
      mem_bus.rsp_valid = 1'b0;
      mem_bus.rsp_err   = 1'b0;
   endtask

   task automatic consume();
      dec_bus.ready = 1'b1;
      step();
      dec_bus.ready = 1'b0;
   endtask

   task automatic test_reset();
      fetch_pkt_t exp;
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      exp = '{inst: 32'h0, imm: 32'h0, pc: 32'h3000_0000, fault: 1'b0};
      checks++; if (mem_bus.req_valid !== 1'b0) $display("FAIL reset_req_valid got %b want 0", mem_bus.req_valid); else passes++;
      checks++; if (dec_bus.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dec_bus.valid); else passes++;
      checks++; if (dec_bus.pkt !== exp) $display("FAIL reset_pkt got %h want %h", dec_bus.pkt, exp); else passes++;
      rst = 1'b0;
      #1;
      checks++; if (mem_bus.req_valid !== 1'b1 || mem_bus.addr !== 32'h3000_0000)
         $display("FAIL first_req got v=%b a=%h want v=1 a=30000000", mem_bus.req_valid, mem_bus.addr); else passes++;
   endtask

   task automatic test_basic();
      fetch_pkt_t exp;
      mem_bus.req_ready = 1'b1;
      step();
      mem_bus.req_ready = 1'b0;
      checks++; if (mem_bus.req_valid !== 1'b0 || dec_bus.valid !== 1'b0)
         $display("FAIL wait_quiet got req=%b v=%b want 0 0", mem_bus.req_valid, dec_bus.valid); else passes++;
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rdata     = 32'h0050_0093;
      step();
      mem_bus.rsp_valid = 1'b0;
      exp = '{inst: 32'h0050_0093, imm: 32'd5, pc: 32'h3000_0000, fault: 1'b0};
      checks++; if (dec_bus.valid !== 1'b1 || dec_bus.pkt !== exp)
         $display("FAIL basic_out got v=%b %h want v=1 %h", dec_bus.valid, dec_bus.pkt, exp); else passes++;
   endtask

   task automatic test_hold();
      fetch_pkt_t exp;
      exp = '{inst: 32'h0050_0093, imm: 32'd5, pc: 32'h3000_0000, fault: 1'b0};
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (dec_bus.valid !== 1'b1 || dec_bus.pkt !== exp || mem_bus.req_valid !== 1'b0)
            $display("FAIL hold_stable[%0d] got v=%b req=%b %h want v=1 req=0 %h",
                     i, dec_bus.valid, mem_bus.req_valid, dec_bus.pkt, exp); else passes++;
      end
      consume();
      checks++; if (dec_bus.valid !== 1'b0 || mem_bus.req_valid !== 1'b1 || mem_bus.addr !== 32'h3000_0004)
         $display("FAIL hold_next got v=%b req=%b a=%h want 0 1 30000004",
                  dec_bus.valid, mem_bus.req_valid, mem_bus.addr); else passes++;
   endtask

   task automatic test_redirect_wait();
      fetch_pkt_t exp;
      mem_bus.req_ready = 1'b1;
      step();
      mem_bus.req_ready = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h3000_0100;
      step();
      redirect = 1'b0;
      checks++; if (dec_bus.valid !== 1'b0 || mem_bus.req_valid !== 1'b0)
         $display("FAIL drop_quiet got v=%b req=%b want 0 0", dec_bus.valid, mem_bus.req_valid); else passes++;
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rdata     = 32'hdead_beef;
      step();
      mem_bus.rsp_valid = 1'b0;
      checks++; if (dec_bus.valid !== 1'b0 || mem_bus.req_valid !== 1'b1 || mem_bus.addr !== 32'h3000_0100)
         $display("FAIL drop_req got v=%b req=%b a=%h want 0 1 30000100",
                  dec_bus.valid, mem_bus.req_valid, mem_bus.addr); else passes++;
      fetch_one(32'hfe01_0113, 1'b0);
      exp = '{inst: 32'hfe01_0113, imm: 32'hffff_ffe0, pc: 32'h3000_0100, fault: 1'b0};
      checks++; if (dec_bus.valid !== 1'b1 || dec_bus.pkt !== exp)
         $display("FAIL redir_out got v=%b %h want v=1 %h", dec_bus.valid, dec_bus.pkt, exp); else passes++;
      consume();
      checks++; if (mem_bus.addr !== 32'h3000_0104)
         $display("FAIL redir_next got a=%h want 30000104", mem_bus.addr); else passes++;
   endtask

   task automatic test_redirect_rsp();
      mem_bus.req_ready = 1'b1;
      step();
      mem_bus.req_ready = 1'b0;
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rdata     = 32'h0050_0093;
      redirect          = 1'b1;
      redirect_pc       = 32'h3000_0200;
      step();
      mem_bus.rsp_valid = 1'b0;
      redirect          = 1'b0;
      checks++; if (dec_bus.valid !== 1'b0 || mem_bus.req_valid !== 1'b1 || mem_bus.addr !== 32'h3000_0200)
         $display("FAIL redir_rsp got v=%b req=%b a=%h want 0 1 30000200",
                  dec_bus.valid, mem_bus.req_valid, mem_bus.addr); else passes++;
   endtask

   task automatic test_redirect_req();
      redirect    = 1'b1;
      redirect_pc = 32'h3000_0400;
      step();
      checks++; if (mem_bus.req_valid !== 1'b1 || mem_bus.addr !== 32'h3000_0400)
         $display("FAIL redir_req_nohs got req=%b a=%h want 1 30000400", mem_bus.req_valid, mem_bus.addr); else passes++;
      mem_bus.req_ready = 1'b1;
      redirect_pc       = 32'h3000_0500;
      step();
      mem_bus.req_ready = 1'b0;
      redirect          = 1'b0;
      checks++; if (mem_bus.req_valid !== 1'b0 || dec_bus.valid !== 1'b0)
         $display("FAIL redir_req_hs got req=%b v=%b want 0 0", mem_bus.req_valid, dec_bus.valid); else passes++;
      mem_bus.rsp_valid = 1'b1;
      step();
      mem_bus.rsp_valid = 1'b0;
      checks++; if (mem_bus.req_valid !== 1'b1 || mem_bus.addr !== 32'h3000_0500 || dec_bus.valid !== 1'b0)
         $display("FAIL redir_req_after got req=%b a=%h v=%b want 1 30000500 0",
                  mem_bus.req_valid, mem_bus.addr, dec_bus.valid); else passes++;
   endtask

   task automatic test_fault();
      fetch_pkt_t exp;
      fetch_one($urandom, 1'b1);
      exp = '{inst: 32'h0000_0013, imm: 32'h0, pc: 32'h3000_0500, fault: 1'b1};
      checks++; if (dec_bus.valid !== 1'b1 || dec_bus.pkt !== exp)
         $display("FAIL bus_err got v=%b %h want v=1 %h", dec_bus.valid, dec_bus.pkt, exp); else passes++;
      redirect    = 1'b1;
      redirect_pc = 32'h3000_0102;
      step();
      redirect = 1'b0;
      checks++; if (dec_bus.valid !== 1'b0 || mem_bus.req_valid !== 1'b0)
         $display("FAIL misalign_noreq got v=%b req=%b want 0 0", dec_bus.valid, mem_bus.req_valid); else passes++;
      step();
      exp = '{inst: 32'h0000_0013, imm: 32'h0, pc: 32'h3000_0102, fault: 1'b1};
      checks++; if (dec_bus.valid !== 1'b1 || dec_bus.pkt !== exp || mem_bus.req_valid !== 1'b0)
         $display("FAIL misalign_out got v=%b req=%b %h want v=1 req=0 %h",
                  dec_bus.valid, mem_bus.req_valid, dec_bus.pkt, exp); else passes++;
      dec_bus.ready = 1'b1;
      redirect      = 1'b1;
      redirect_pc   = 32'h3000_0600;
      step();
      dec_bus.ready = 1'b0;
      redirect      = 1'b0;
      checks++; if (dec_bus.valid !== 1'b0 || mem_bus.req_valid !== 1'b1 || mem_bus.addr !== 32'h3000_0600)
         $display("FAIL fault_exit got v=%b req=%b a=%h want 0 1 30000600",
                  dec_bus.valid, mem_bus.req_valid, mem_bus.addr); else passes++;
   endtask

   task automatic test_imm();
      logic [31:0] words [5];
      logic [31:0] imms  [5];
      fetch_pkt_t  exp;
      words = '{32'hfe01_0113, 32'h0000_0517, 32'hfe5f_f06f, 32'hfe11_2e23, 32'hfe00_08e3};
      imms  = '{-32'sd32, 32'h0, -32'sd28, -32'sd4, -32'sd16};
      for (int i = 0; i < 5; i++) begin
         fetch_one(words[i], 1'b0);
         exp = '{inst: words[i], imm: imms[i], pc: 32'h3000_0600 + 32'(i * 4), fault: 1'b0};
         checks++; if (dec_bus.valid !== 1'b1 || dec_bus.pkt !== exp)
            $display("FAIL imm[%0d] got v=%b %h want v=1 %h", i, dec_bus.valid, dec_bus.pkt, exp); else passes++;
         consume();
      end
   endtask

   task automatic test_wrap();
      redirect    = 1'b1;
      redirect_pc = 32'hffff_fffc;
      step();
      redirect = 1'b0;
      fetch_one(32'h0050_0093, 1'b0);
      checks++; if (dec_bus.pkt.pc !== 32'hffff_fffc)
         $display("FAIL wrap_pc got %h want fffffffc", dec_bus.pkt.pc); else passes++;
      consume();
      checks++; if (mem_bus.req_valid !== 1'b1 || mem_bus.addr !== 32'h0)
         $display("FAIL wrap_next got req=%b a=%h want 1 00000000", mem_bus.req_valid, mem_bus.addr); else passes++;
      redirect    = 1'b1;
      redirect_pc = 32'h3000_1000;
      step();
      redirect = 1'b0;
   endtask

   // Random memory latency, memory stalls, decode stalls and bus errors; no redirects.
   task automatic test_random();
      fetch_pkt_t  expq [$];
      fetch_pkt_t  exp;
      fetch_pkt_t  prev_pkt;
      logic [31:0] exp_addr = 32'h3000_1000;
      logic [31:0] pend_addr = 32'h0;
      bit          pending = 0;
      bit          prev_hold = 0;
      bit          prev_rsp = 0;
      int          lat = 0;
      int          consumed = 0;
      prev_pkt = '0;
      for (int c = 0; c < 600; c++) begin
         step();
         mem_bus.req_ready = 1'($urandom_range(0, 1));
         mem_bus.rsp_valid = 1'b0;
         mem_bus.rsp_err   = 1'b0;
         mem_bus.rdata     = $urandom;
         if (pending) begin
            lat--;
            if (lat == 0) begin
               mem_bus.rsp_valid = 1'b1;
               mem_bus.rsp_err   = ($urandom_range(0, 7) == 0);
               mem_bus.rdata     = rand_inst();
            end
         end
         dec_bus.ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         checks++; if (dec_bus.valid === 1'b1 && mem_bus.req_valid === 1'b1)
            $display("FAIL rnd_exclusive cycle %0d got valid=1 req_valid=1 want not both", c); else passes++;
         if (prev_hold) begin
            checks++; if (dec_bus.valid !== 1'b1 || dec_bus.pkt !== prev_pkt)
               $display("FAIL rnd_stable cycle %0d got v=%b %h want v=1 %h", c, dec_bus.valid, dec_bus.pkt, prev_pkt); else passes++;
         end
         if (prev_rsp) begin
            checks++; if (dec_bus.valid !== 1'b1)
               $display("FAIL rnd_latency cycle %0d got valid=%b want 1", c, dec_bus.valid); else passes++;
         end
         if (mem_bus.rsp_valid) begin
            pending = 0;
            if (mem_bus.rsp_err) exp = '{inst: 32'h13, imm: 32'h0, pc: pend_addr, fault: 1'b1};
            else                 exp = '{inst: mem_bus.rdata, imm: ref_imm(mem_bus.rdata), pc: pend_addr, fault: 1'b0};
            expq.push_back(exp);
         end
         if (mem_bus.req_valid && mem_bus.req_ready) begin
            checks++; if (mem_bus.addr !== exp_addr || pending)
               $display("FAIL rnd_req cycle %0d got a=%h outstanding=%0d want a=%h outstanding=0",
                        c, mem_bus.addr, pending, exp_addr); else passes++;
            exp_addr  = exp_addr + 32'd4;
            pend_addr = mem_bus.addr;
            pending   = 1;
            lat       = $urandom_range(1, 3);
         end
         if (dec_bus.valid && dec_bus.ready) begin
            checks++;
            if (expq.size() == 0) $display("FAIL rnd_pkt cycle %0d got %h want nothing", c, dec_bus.pkt);
            else begin
               exp = expq.pop_front();
               if (dec_bus.pkt !== exp) $display("FAIL rnd_pkt cycle %0d got %h want %h", c, dec_bus.pkt, exp);
               else passes++;
            end
            consumed++;
         end
         prev_hold = dec_bus.valid && !dec_bus.ready;
         prev_rsp  = mem_bus.rsp_valid;
         prev_pkt  = dec_bus.pkt;
      end
      checks++; if (consumed < 40)
         $display("FAIL rnd_progress got %0d instructions want at least 40", consumed); else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_redirect_wait();
      test_redirect_rsp();
      test_redirect_req();
      test_fault();
      test_imm();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
